cc_decoder: RTL

- Serial receive side of the (7,4) cyclic Hamming link: accepts the bit stream the encoder produces, computes the syndrome with a serial LFSR divider, corrects any single-bit error and presents the 4-bit message in parallel.
- Sits at the channel output, after the encoder's serializer and any error-injection stage.
- Code definition: generator g(x)=x^3+x+1. Codeword c6..c0 = {d3,d2,d1,d0,p2,p1,p0}, where p(x) = d(x)·x^3 mod g(x). Transmission order is c6 first, c0 last.

---
 rtl/cc_decoder.sv | 109 ++++++++++
 1 files changed

// File: rtl/cc_decoder.sv
// Serial (7,4) cyclic Hamming decoder, g(x)=x^3+x+1: LFSR syndrome, single-bit correction.
// Optional macro ERR_COUNT_EN builds a saturating corrected-frame counter on err_count.
module cc_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_in,
  input  logic             in_valid,
  input  logic             sof,
  output logic [3:0]       data_out,
  output logic             out_valid,
  output logic             err_flag,
  output logic [2:0]       err_pos,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [2:0] syn_q;
  logic [6:0] buf_q;

  logic       start;
  logic       done;
  logic [2:0] syn_d;
  logic [6:0] buf_d;
  logic [2:0] pos;
  logic [3:0] dflip;

  function automatic logic [2:0] syn_step(input logic [2:0] s, input logic b);
    return {s[1], s[0] ^ s[2], b ^ s[2]};
  endfunction

  // Syndrome equals x^i mod g(x) for a single error at bit i.
  function automatic logic [2:0] syn_to_pos(input logic [2:0] s);
    case (s)
      3'b001:  return 3'd0;
      3'b010:  return 3'd1;
      3'b100:  return 3'd2;
      3'b011:  return 3'd3;
      3'b110:  return 3'd4;
      3'b111:  return 3'd5;
      3'b101:  return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  assign start = in_valid && sof;
  assign done  = (state_q == RECV) && (cnt_q == 3'd7);
  assign syn_d = syn_step(start ? 3'b000 : syn_q, code_in);
  assign buf_d = start ? {6'b0, code_in} : {buf_q[5:0], code_in};
  assign pos   = syn_to_pos(syn_q);
  assign dflip = (pos >= 3'd3) ? (4'd1 << (pos - 3'd3)) : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      syn_q     <= 3'd0;
      buf_q     <= 7'd0;
      data_out  <= 4'd0;
      out_valid <= 1'b0;
      err_flag  <= 1'b0;
      err_pos   <= 3'd0;
    end else begin
      out_valid <= 1'b0;
      // Completion edge: the frame's last bit was accepted on the previous edge.
      if (done) begin
        out_valid <= 1'b1;
        data_out  <= buf_q[6:3] ^ dflip;
        err_flag  <= |syn_q;
        err_pos   <= pos;
      end
      // A sof always wins: it aborts a partial frame or chains after a finished one.
      if (start) begin
        state_q <= RECV;
        cnt_q   <= 3'd1;
        syn_q   <= syn_d;
        buf_q   <= buf_d;
      end else if (done) begin
        state_q <= IDLE;
        cnt_q   <= 3'd0;
      end else if (state_q == RECV && in_valid) begin
        cnt_q <= cnt_q + 3'd1;
        syn_q <= syn_d;
        buf_q <= buf_d;
      end
    end
  end

`ifdef ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (done && (|syn_q) && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule
